// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX AXI-Stream packet arbiter.
// No logic of its own; rr_pick is pure combinational.
// No flow control here; used by tx_axis_arb.
package tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int N_REQ_MAX = 8;

    // First set bit of eligible at or after ptr, wrapping modulo n.
    // Returns 0 when nothing is eligible; callers gate on |eligible.
    function automatic int unsigned rr_pick(
        input logic [N_REQ_MAX-1:0] eligible,
        input logic [2:0]           ptr,
        input int unsigned          n
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ_MAX; i++) begin
            idx = (32'(ptr) + i) % n;
            if ((i < n) && !found && eligible[idx[2:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice carrying tdata/tkeep/tlast.
// Latency: 1 cycle from input acceptance to output valid; 1 beat/cycle sustained.
// Backpressure: in_tready is registered and low only while both entries are held.
module axis_skid_buf
    import tx_arb_pkg::*;
#(
    parameter int DWIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH-1:0]     in_tdata,
    input  logic [DWIDTH/8-1:0]   in_tkeep,
    input  logic                  in_tlast,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DWIDTH-1:0]     out_tdata,
    output logic [DWIDTH/8-1:0]   out_tkeep,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    input  logic                  out_tready
);

    localparam int KW = DWIDTH/8;

    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic [DWIDTH-1:0] sk_tdata;
    logic [KW-1:0]     sk_tkeep;
    logic              sk_tlast;
    logic              push;
    logic              pop;

    assign push = in_tvalid & in_tready;
    assign pop  = out_tvalid & out_tready;

    // Occupancy after this cycle's handshakes; drives the registered ready/valid.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + 2'd1;
        end else if (pop && !push) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    // Output register is the head entry; the skid register only fills when
    // the head is stalled, and drains into the head on the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            in_tready  <= 1'b1;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tlast  <= 1'b0;
            sk_tdata   <= '0;
            sk_tkeep   <= '0;
            sk_tlast   <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            in_tready  <= (cnt_nxt != 2'd2);
            out_tvalid <= (cnt_nxt != 2'd0);
            if (pop && (cnt == 2'd2)) begin
                out_tdata <= sk_tdata;
                out_tkeep <= sk_tkeep;
                out_tlast <= sk_tlast;
            end else if (push && ((cnt == 2'd0) || pop)) begin
                out_tdata <= in_tdata;
                out_tkeep <= in_tkeep;
                out_tlast <= in_tlast;
            end
            if (push && !pop && (cnt == 2'd1)) begin
                sk_tdata <= in_tdata;
                sk_tkeep <= in_tkeep;
                sk_tlast <= in_tlast;
            end
        end
    end

endmodule

// File: rtl/tx_axis_arb.sv
// Packet-level round-robin arbiter: N_REQ AXI-Stream ports onto one TX datapath.
// Latency: 1 cycle arbitration, then 1 cycle per beat through the output slice.
// Backpressure: only the granted port sees ready, which follows the slice's registered ready.
module tx_axis_arb
    import tx_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DWIDTH = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            port_en,
    input  logic [N_REQ*DWIDTH-1:0]     s_axis_tdata,
    input  logic [N_REQ*DWIDTH/8-1:0]   s_axis_tkeep,
    input  logic [N_REQ-1:0]            s_axis_tlast,
    input  logic [N_REQ-1:0]            s_axis_tvalid,
    output logic [N_REQ-1:0]            s_axis_tready,
    output logic [DWIDTH-1:0]           m_axis_tdata,
    output logic [DWIDTH/8-1:0]         m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);

    localparam int KW = DWIDTH/8;
    localparam int GW = $clog2(N_REQ);

    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  eligible;
    logic [DWIDTH-1:0] sel_tdata;
    logic [KW-1:0]     sel_tkeep;
    logic              sel_tlast;
    logic              skid_in_vld;
    logic              skid_in_rdy;
    logic              accept;

    assign eligible = s_axis_tvalid & port_en;
    assign accept   = skid_in_vld & skid_in_rdy;

    // Route the granted port into the slice; ready goes back to that port only.
    always_comb begin
        sel_tdata     = s_axis_tdata[grant_id*DWIDTH +: DWIDTH];
        sel_tkeep     = s_axis_tkeep[grant_id*KW +: KW];
        sel_tlast     = s_axis_tlast[grant_id];
        skid_in_vld   = 1'b0;
        s_axis_tready = '0;
        if (state == XFER) begin
            skid_in_vld             = s_axis_tvalid[grant_id];
            s_axis_tready[grant_id] = skid_in_rdy;
        end
    end

    // Arbitration FSM: grant is held until the granted tlast is accepted,
    // and the pointer moves past the winner so every enabled port gets a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        grant_id <= GW'(rr_pick(N_REQ_MAX'(eligible), 3'(rr_ptr), N_REQ));
                        state    <= XFER;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept && sel_tlast) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= (grant_id == GW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    axis_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tdata   (sel_tdata),
        .in_tkeep   (sel_tkeep),
        .in_tlast   (sel_tlast),
        .in_tvalid  (skid_in_vld),
        .in_tready  (skid_in_rdy),
        .out_tdata  (m_axis_tdata),
        .out_tkeep  (m_axis_tkeep),
        .out_tlast  (m_axis_tlast),
        .out_tvalid (m_axis_tvalid),
        .out_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_tx_axis_arb.sv
// Directed bench for tx_axis_arb: per-cycle vector table plus hand sequences.
// Latency: expected values encode 1-cycle grant and 1-cycle slice latency.
// Backpressure: exercised by stalling m_axis_tready during a long packet.
module tb_tx_axis_arb;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int KW = DW/8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    port_en;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [1:0]      grant_id;
    logic            busy;

    int ntot = 0;
    int nbad = 0;

    tx_axis_arb #(.N_REQ(N), .DWIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_en       (port_en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", ntot, nbad);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] vld, lst, en;
        logic       mrdy, zk;
        logic [3:0] rdy;
        logic       busy;
        logic [1:0] gid;
        logic       mvld, mlast;
        int         mport;
        logic [7:0] mtag;
        logic       mzk;
    } vec_t;

    vec_t tv[$];

    function automatic logic [DW-1:0] mkdat(input int p, input logic [7:0] tag);
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = {8'hA5 ^ 8'(w), 8'(w), 8'(p), tag};
        return d;
    endfunction

    function automatic logic [KW-1:0] mkkeep(input int p, input logic [7:0] tag);
        return {tag, ~tag, 8'(p), 8'h5A};
    endfunction

    function automatic void add(input int vld, input int lst, input int en, input int mrdy,
                                input int zk, input int rdy, input int bsy, input int gid,
                                input int mvld, input int mlast, input int mport,
                                input int mtag, input int mzk);
        vec_t v;
        v.vld = 4'(vld);  v.lst = 4'(lst);  v.en = 4'(en);
        v.mrdy = 1'(mrdy); v.zk = 1'(zk);   v.rdy = 4'(rdy);
        v.busy = 1'(bsy); v.gid = 2'(gid);  v.mvld = 1'(mvld);
        v.mlast = 1'(mlast); v.mport = mport; v.mtag = 8'(mtag); v.mzk = 1'(mzk);
        tv.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic l,
                            input logic [7:0] tag, input logic zk);
        s_tdata[p*DW +: DW] = mkdat(p, tag);
        s_tkeep[p*KW +: KW] = zk ? '0 : mkkeep(p, tag);
        s_tvalid[p] = v;
        s_tlast[p]  = l;
    endtask

    task automatic idle_all();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tready"}, DW'(s_tready), DW'(0));
        chk({tag, " m_tvalid"}, DW'(m_tvalid), DW'(0));
        chk({tag, " m_tdata"}, m_tdata, DW'(0));
        chk({tag, " m_tkeep"}, DW'(m_tkeep), DW'(0));
        chk({tag, " m_tlast"}, DW'(m_tlast), DW'(0));
        chk({tag, " busy"}, DW'(busy), DW'(0));
        chk({tag, " grant_id"}, DW'(grant_id), DW'(0));
    endtask

    initial begin
        int sent, sent0, rcv, viol, p1_last_c, p0_acc_c;
        int out_c[6];
        int ep[6];
        logic [7:0] et[6];
        logic el[6];

        rst_n = 1'b0;
        port_en = 4'hF;
        m_tready = 1'b1;
        idle_all();

        // vld  lst  en  mrdy zk | rdy busy gid mvld mlast mport mtag mzk
        // round robin 0,1,2,3 then 0 with 2-beat packets (port 0 last is 1 beat)
        add(15, 0, 15, 1, 0,   0, 0, 0, 0, 0, 0,  0, 0);
        add(15, 0, 15, 1, 0,   1, 1, 0, 0, 0, 0,  0, 0);
        add(15, 1, 15, 1, 0,   1, 1, 0, 1, 0, 0,  1, 0);
        add(15, 0, 15, 1, 0,   0, 0, 0, 1, 1, 0,  2, 0);
        add(15, 0, 15, 1, 0,   2, 1, 1, 0, 0, 0,  0, 0);
        add(15, 2, 15, 1, 0,   2, 1, 1, 1, 0, 1,  4, 0);
        add(15, 0, 15, 1, 0,   0, 0, 1, 1, 1, 1,  5, 0);
        add(15, 0, 15, 1, 0,   4, 1, 2, 0, 0, 0,  0, 0);
        add(15, 4, 15, 1, 0,   4, 1, 2, 1, 0, 2,  7, 0);
        add(15, 0, 15, 1, 0,   0, 0, 2, 1, 1, 2,  8, 0);
        add(15, 0, 15, 1, 0,   8, 1, 3, 0, 0, 0,  0, 0);
        add(15, 8, 15, 1, 0,   8, 1, 3, 1, 0, 3, 10, 0);
        add(15, 0, 15, 1, 0,   0, 0, 3, 1, 1, 3, 11, 0);
        add( 1, 1, 15, 1, 0,   1, 1, 0, 0, 0, 0,  0, 0);
        add( 0, 0, 15, 1, 0,   0, 0, 0, 1, 1, 0, 13, 0);
        add( 0, 0, 15, 1, 0,   0, 0, 0, 0, 0, 0,  0, 0);
        // port_en 1011: port 2 skipped; port 1's packet survives clearing en[1]
        add(15, 0, 11, 1, 0,   0, 0, 0, 0, 0, 0,  0, 0);
        add(15, 0,  9, 1, 0,   2, 1, 1, 0, 0, 0,  0, 0);
        add(15, 2,  9, 1, 0,   2, 1, 1, 1, 0, 1, 17, 0);
        add(15, 0, 11, 1, 0,   0, 0, 1, 1, 1, 1, 18, 0);
        add(15, 8, 11, 1, 0,   8, 1, 3, 0, 0, 0,  0, 0);
        add(15, 0, 11, 1, 0,   0, 0, 3, 1, 1, 3, 20, 0);
        add(15, 1, 11, 1, 0,   1, 1, 0, 0, 0, 0,  0, 0);
        add(15, 0, 11, 1, 0,   0, 0, 0, 1, 1, 0, 22, 0);
        add(15, 2, 11, 1, 0,   2, 1, 1, 0, 0, 0,  0, 0);
        add(15, 0, 11, 1, 0,   0, 0, 1, 1, 1, 1, 24, 0);
        add(15, 8, 11, 1, 1,   8, 1, 3, 0, 0, 0,  0, 0);
        add( 0, 0, 15, 1, 0,   0, 0, 3, 1, 1, 3, 26, 1);
        add( 0, 0, 15, 1, 0,   0, 0, 3, 0, 0, 0,  0, 0);
        // single port 0, 3-beat packet
        add( 1, 0, 15, 1, 0,   0, 0, 3, 0, 0, 0,  0, 0);
        add( 1, 0, 15, 1, 0,   1, 1, 0, 0, 0, 0,  0, 0);
        add( 1, 0, 15, 1, 0,   1, 1, 0, 1, 0, 0, 30, 0);
        add( 1, 1, 15, 1, 0,   1, 1, 0, 1, 0, 0, 31, 0);
        add( 0, 0, 15, 1, 0,   0, 0, 0, 1, 1, 0, 32, 0);
        add( 0, 0, 15, 1, 0,   0, 0, 0, 0, 0, 0,  0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        foreach (tv[r]) begin
            @(posedge clk); #1;
            for (int p = 0; p < N; p++) set_port(p, tv[r].vld[p], tv[r].lst[p], 8'(r), tv[r].zk);
            port_en  = tv[r].en;
            m_tready = tv[r].mrdy;
            @(negedge clk);
            chk($sformatf("row%0d tready", r), DW'(s_tready), DW'(tv[r].rdy));
            chk($sformatf("row%0d busy", r), DW'(busy), DW'(tv[r].busy));
            chk($sformatf("row%0d grant_id", r), DW'(grant_id), DW'(tv[r].gid));
            chk($sformatf("row%0d m_tvalid", r), DW'(m_tvalid), DW'(tv[r].mvld));
            if (tv[r].mvld) begin
                chk($sformatf("row%0d m_tlast", r), DW'(m_tlast), DW'(tv[r].mlast));
                chk($sformatf("row%0d m_tdata", r), m_tdata, mkdat(tv[r].mport, tv[r].mtag));
                chk($sformatf("row%0d m_tkeep", r), DW'(m_tkeep),
                    tv[r].mzk ? DW'(0) : DW'(mkkeep(tv[r].mport, tv[r].mtag)));
            end
        end

        // ---------------- port 1 long packet, port 0 arrives mid-packet ----------------
        ep = '{1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin et[i] = 8'h20 + 8'(i); el[i] = (i == 4); end
        et[5] = 8'h30; el[5] = 1'b1;
        sent = 0; sent0 = 0; rcv = 0; viol = 0; p1_last_c = -100; p0_acc_c = -1;
        port_en = 4'hF; m_tready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            set_port(1, sent < 5, sent == 4, 8'h20 + 8'(sent), 1'b0);
            set_port(0, (c >= 2) && (sent0 < 1), 1'b1, 8'h30, 1'b0);
            @(negedge clk);
            if (s_tready[0] && (sent < 5)) viol++;
            if ((s_tready & 4'b1100) != 4'b0000) viol++;
            if (s_tready[0] && s_tvalid[0]) begin p0_acc_c = c; sent0++; end
            if (s_tready[1] && s_tvalid[1]) begin if (sent == 4) p1_last_c = c; sent++; end
            if (m_tvalid) begin
                if (rcv < 6) begin
                    chk($sformatf("mid beat%0d data", rcv), m_tdata, mkdat(ep[rcv], et[rcv]));
                    chk($sformatf("mid beat%0d last", rcv), DW'(m_tlast), DW'(el[rcv]));
                    out_c[rcv] = c;
                end
                rcv++;
            end
        end
        chk("mid beats out", DW'(rcv), DW'(6));
        chk("mid port1 contiguous", DW'(out_c[4] - out_c[0]), DW'(4));
        chk("mid ready violations", DW'(viol), DW'(0));
        chk("mid port0 after bubble", DW'(p0_acc_c - p1_last_c), DW'(2));
        idle_all();

        // ---------------- backpressure on port 2, 6-beat packet ----------------
        sent = 0; rcv = 0; viol = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            set_port(2, sent < 6, sent == 5, 8'h40 + 8'(sent), 1'b0);
            m_tready = !((c == 3) || (c == 4));
            @(negedge clk);
            if ((s_tready & 4'b1011) != 4'b0000) viol++;
            if (c == 3) chk("bp ready one held", DW'(s_tready), DW'(4'b0100));
            if ((c == 4) || (c == 5)) chk($sformatf("bp ready full c%0d", c), DW'(s_tready), DW'(0));
            if ((c >= 3) && (c <= 5)) begin
                chk($sformatf("bp stall valid c%0d", c), DW'(m_tvalid), DW'(1));
                chk($sformatf("bp stall data c%0d", c), m_tdata, mkdat(2, 8'h41));
            end
            if (s_tready[2] && s_tvalid[2]) sent++;
            if (m_tvalid && m_tready) begin
                if (rcv < 6) begin
                    chk($sformatf("bp beat%0d data", rcv), m_tdata, mkdat(2, 8'h40 + 8'(rcv)));
                    chk($sformatf("bp beat%0d last", rcv), DW'(m_tlast), DW'(rcv == 5));
                end
                rcv++;
            end
        end
        chk("bp beats in", DW'(sent), DW'(6));
        chk("bp beats out", DW'(rcv), DW'(6));
        chk("bp ready violations", DW'(viol), DW'(0));
        chk("bp busy after", DW'(busy), DW'(0));
        idle_all();

        // ---------------- asynchronous reset mid-packet ----------------
        m_tready = 1'b0;
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b0, 8'h50, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pre ready", DW'(s_tready), DW'(4'b0010));
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b0, 8'h51, 1'b0);
        #1;
        chk("rst pre m_tvalid", DW'(m_tvalid), DW'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst async");
        idle_all();
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_port(3, 1'b1, 1'b1, 8'h60, 1'b0);
        m_tready = 1'b1;
        @(negedge clk);
        chk("post rst idle busy", DW'(busy), DW'(0));
        chk("post rst idle ready", DW'(s_tready), DW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("post rst grant", DW'(grant_id), DW'(3));
        chk("post rst busy", DW'(busy), DW'(1));
        chk("post rst ready", DW'(s_tready), DW'(4'b1000));
        @(posedge clk); #1;
        set_port(3, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("post rst m_tvalid", DW'(m_tvalid), DW'(1));
        chk("post rst m_tdata", m_tdata, mkdat(3, 8'h60));
        chk("post rst m_tkeep", DW'(m_tkeep), DW'(mkkeep(3, 8'h60)));
        chk("post rst m_tlast", DW'(m_tlast), DW'(1));
        chk("post rst busy done", DW'(busy), DW'(0));

        // ---------------- reset returns the round-robin pointer to 0 ----------------
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 8'h70, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 8'h71, 1'b0);
        set_port(1, 1'b1, 1'b1, 8'h72, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr reset grant", DW'(grant_id), DW'(0));
        chk("rr reset ready", DW'(s_tready), DW'(4'b0001));
        @(posedge clk); #1;
        idle_all();
        repeat (6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule

// File: doc/tx_axis_arb.md
# tx_axis_arb

Packet-level round-robin arbiter that shares one TX AXI-Stream datapath (the 256-bit user-side input of the TX width converter) between N_REQ user streams. A granted port keeps the path until its tlast beat is accepted, so packets are never interleaved. A 2-entry skid buffer registers the output and closes timing toward the converter. A per-port enable mask lets software exclude ports from arbitration.

## Interface
Parameters:
- N_REQ, 4, number of requesting streams (2..8)
- DWIDTH, 256, tdata width per stream; tkeep is DWIDTH/8

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset; asynchronous assert, active-low
- port_en  in  N_REQ  per-port arbitration enable; sampled only at arbitration
- s_axis_tdata  in  N_REQ*DWIDTH  port i occupies bits [(i+1)*DWIDTH-1 -: DWIDTH]
- s_axis_tkeep  in  N_REQ*DWIDTH/8  packed per port, same ordering
- s_axis_tlast  in  N_REQ  per-port end of packet
- s_axis_tvalid  in  N_REQ  per-port valid
- s_axis_tready  out  N_REQ  per-port ready; at most one bit high
- m_axis_tdata  out  DWIDTH  to converter
- m_axis_tkeep  out  DWIDTH/8
- m_axis_tlast  out  1
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- grant_id  out  $clog2(N_REQ)  currently or last granted port
- busy  out  1  high in XFER

## Operation
- FSM states: IDLE, XFER.
- IDLE: eligible = s_axis_tvalid & port_en. If any bit is set, pick the first eligible port at or after rr_ptr, wrapping modulo N_REQ. Register the choice into grant_id and go to XFER. All s_axis_tready are low in IDLE.
- XFER: s_axis_tready[grant_id] = skid_in_ready; all other ready bits are 0. The granted port's tdata/tkeep/tlast/tvalid are muxed into the skid buffer.
- On an accepted beat with tlast (granted tvalid & tready & tlast): go to IDLE and set rr_ptr = grant_id+1, wrapping N_REQ-1 to 0.
- port_en changes during XFER do not affect the current packet.
- Beats with tkeep all zero pass through unchanged. The block never modifies tdata, tkeep or tlast.
- Skid buffer: 2 entries, 1 beat/cycle sustained. skid_in_ready is registered and equals "fewer than 2 entries held".
- Reset values: FSM IDLE, rr_ptr 0, grant_id 0, busy 0, skid empty, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tkeep 0, m_axis_tlast 0, all s_axis_tready 0.
- Reset asserted mid-packet: all buffered beats are discarded, state returns to IDLE, rr_ptr returns to 0. Upstream must restart the packet.

## Timing
- Arbitration: eligible in cycle t (IDLE) → grant_id and busy valid at t+1 → s_axis_tready[grant] may be high at t+1.
- First beat accepted at t+1 → m_axis_tvalid at t+2. Pipeline latency is 1 cycle per beat after acceptance.
- One IDLE bubble per packet: beat k+1 of the next packet is accepted no earlier than 1 cycle after the previous tlast is accepted. A single-beat packet occupies XFER for one cycle.
- Backpressure: if m_axis_tready is low, the skid absorbs up to 2 beats. s_axis_tready falls the cycle after the skid becomes full, with no data loss.
- AXIS rules: m_axis_tvalid never drops and m_axis_tdata never changes until the beat is accepted. Granted upstream valid-before-ready is not required.
- Simultaneous requests in IDLE are resolved purely by rr_ptr.

## Structure
- Package tx_arb_pkg holds:
  - state_t enum {IDLE, XFER}
  - localparam N_REQ_MAX = 8
  - function rr_pick(eligible, ptr) returning the first set index at or after ptr, with wrap
- Sub-module axis_skid_buf (params DWIDTH): 2-entry AXIS register slice carrying tdata/tkeep/tlast, same clk/rst_n, registered ready. It is reusable at the converter output.

## Test plan
- Single port 0 sends a 3-beat packet (tlast on beat 3), m_axis_tready=1 → grant_id=0, output beats appear at t+2..t+4 identical to input, busy falls after the last beat.
- Ports 0–3 each valid with 2-beat packets, rr_ptr=0 → output order 0,1,2,3, then 0. Exactly one IDLE cycle between packets. No s_axis_tready on non-granted ports.
- Port 1 holds a 5-beat packet while port 0 asserts valid mid-packet → port 1's beats are contiguous, port 0 is granted only after port 1's tlast.
- m_axis_tready toggles 1,0,0,1 during a 6-beat packet → no beat lost or duplicated, s_axis_tready low while the skid is full, stable output during stalls.
- port_en=4'b1011 with all ports valid → port 2 is never granted. Clearing port_en[1] during port 1's packet → that packet still completes.
- rst_n asserted during beat 2 of 4 → outputs return to reset values asynchronously. After release, a new packet from port 3 is granted with rr_ptr=0 logic (ports 0–2 idle).
